// File: rtl/m_imem_loader_pkg.sv
// Shared constants and state encodings for the serial instruction-memory loader.
package m_imem_loader_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/m_imem_loader_if.sv
// Memory write port and load status driven by the loader.
interface m_imem_loader_if #(
    parameter int ADDR_W = 12
);

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    modport master (
        output r_we, r_addr, r_wdata, r_busy, r_done, r_err
    );

    modport slave (
        input r_we, r_addr, r_wdata, r_busy, r_done, r_err
    );

endinterface

// File: rtl/m_imem_loader_uart_rx.sv
// 8N1 UART byte receiver with input synchronizer, start-glitch rejection
// and framing-error reporting.
module m_uart_rx
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       w_rxd,
    output logic [7:0] r_byte,
    output logic       r_valid,
    output logic       r_ferr
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_line;
    logic             fall;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       byte_d;
    logic             valid_d, ferr_d;

    assign rx_line = sync_q[1];
    assign fall    = prev_q & ~rx_line;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], w_rxd};
            prev_q  <= rx_line;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            r_byte  <= byte_d;
            r_valid <= valid_d;
            r_ferr  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        byte_d  = r_byte;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_line, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_line) begin
                        valid_d = 1'b1;
                        byte_d  = sh_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/m_imem_loader.sv
// Packet loader: parses A5 / count / big-endian words from the UART and
// writes them to consecutive instruction-memory words from address 0.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_rxd,
    m_imem_loader_if.master bus
);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;

    ld_state_e         state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0]       len;
    logic [31:0]       word;
    logic [ADDR_W:0]   idx_inc;

    m_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .w_rxd  (w_rxd),
        .r_byte (rx_byte),
        .r_valid(rx_valid),
        .r_ferr (rx_ferr)
    );

    assign bus.r_we    = we_q;
    assign bus.r_addr  = addr_q;
    assign bus.r_wdata = wdata_q;
    assign bus.r_busy  = busy_q;
    assign bus.r_done  = done_q;
    assign bus.r_err   = err_q;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        len     = {hi_q, rx_byte};
        word    = {asm_q, rx_byte};
        idx_inc = idx_q + 1'b1;

        if (rx_ferr && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_byte == HEADER_BYTE)) begin
                        state_d = ST_LEN_H;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_LEN_H: begin
                    if (rx_valid) begin
                        hi_d    = rx_byte;
                        state_d = ST_LEN_L;
                    end
                end
                ST_LEN_L: begin
                    if (rx_valid) begin
                        // 32-bit compare keeps the upper bound exact for any ADDR_W.
                        if ((len == 16'd0) || (32'(len) > (32'd1 << ADDR_W))) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                            count_d = (ADDR_W+1)'(len);
                            idx_d   = '0;
                            bcnt_d  = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        asm_d  = word[23:0];
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == 2'd3) begin
                            we_d    = 1'b1;
                            wdata_d = word;
                            addr_d  = idx_q[ADDR_W-1:0];
                            idx_d   = idx_inc;
                            if (idx_inc == count_q) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench: frame table plus hand sequences, writes checked by a scoreboard.
module tb_m_imem_loader;

    localparam int CPB    = 4;
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              last;
    } exp_t;

    typedef struct packed {
        logic [95:0] b;
        logic [3:0]  nb;
        logic [63:0] w;
        logic [1:0]  nw;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    int   tests = 0;
    int   fails = 0;
    bit   chk_done_next = 1'b0;
    exp_t sb[$];
    vec_t vt[4];

    m_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    m_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W)
    ) dut (
        .w_clk  (clk),
        .w_rst_n(rst_n),
        .w_rxd  (rxd),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(CPB);
        end
        rxd = stop_ok;
        cyc(CPB);
        rxd = 1'b1;
        cyc(2 * CPB);
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit last);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bus.r_we),    32'd0);
        check({tag, "_addr"},  32'(bus.r_addr),  32'd0);
        check({tag, "_wdata"}, bus.r_wdata,      32'd0);
        check({tag, "_busy"},  32'(bus.r_busy),  32'd0);
        check({tag, "_done"},  32'(bus.r_done),  32'd0);
        check({tag, "_err"},   32'(bus.r_err),   32'd0);
    endtask

    // Scoreboard: every write must match the oldest expected one; the cycle
    // after the final write of a load must show busy low and done high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_done_next) begin
                check("busy_fall", 32'(bus.r_busy), 32'd0);
                check("done_rise", 32'(bus.r_done), 32'd1);
                chk_done_next = 1'b0;
            end
            if (bus.r_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_we", 32'(bus.r_we), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(bus.r_addr), 32'(e.addr));
                    check("wr_data", bus.r_wdata, e.data);
                    if (e.last) chk_done_next = 1'b1;
                end
            end
        end
    end

    initial begin
        vt[0] = '{b: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                      8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00},
                  nb: 4'd11, w: {32'h12345678, 32'hDEADBEEF}, nw: 2'd2,
                  exp_done: 1'b1, exp_err: 1'b0};
        vt[1] = '{b: {8'h3C, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h2A, 32'h0},
                  nb: 4'd8, w: {32'h0000002A, 32'h0}, nw: 2'd1,
                  exp_done: 1'b1, exp_err: 1'b0};
        vt[2] = '{b: {8'hA5, 8'h00, 8'h00, 72'h0},
                  nb: 4'd3, w: 64'h0, nw: 2'd0,
                  exp_done: 1'b0, exp_err: 1'b1};
        vt[3] = '{b: {8'hA5, 8'h10, 8'h01, 72'h0},
                  nb: 4'd3, w: 64'h0, nw: 2'd0,
                  exp_done: 1'b0, exp_err: 1'b1};

        cyc(5);
        rst_n = 1'b1;
        cyc(100);
        check_all_zero("reset_idle");

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < int'(vt[v].nw); k++) begin
                push_exp(ADDR_W'(k), vt[v].w[63 - 32*k -: 32], k == int'(vt[v].nw) - 1);
            end
            for (int i = 0; i < int'(vt[v].nb); i++) begin
                send_byte(vt[v].b[95 - 8*i -: 8], 1'b1);
            end
            cyc(10);
            check($sformatf("vec%0d_done", v), 32'(bus.r_done), 32'(vt[v].exp_done));
            check($sformatf("vec%0d_err", v),  32'(bus.r_err),  32'(vt[v].exp_err));
            check($sformatf("vec%0d_busy", v), 32'(bus.r_busy), 32'd0);
            check($sformatf("vec%0d_pending", v), 32'(sb.size()), 32'd0);
        end

        // Framing error in the 6th data byte after one complete word.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        check("busy_during_load", 32'(bus.r_busy), 32'd1);
        push_exp('0, 32'h11223344, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        cyc(10);
        check("ferr_err",  32'(bus.r_err),  32'd1);
        check("ferr_busy", 32'(bus.r_busy), 32'd0);
        check("ferr_done", 32'(bus.r_done), 32'd0);
        check("ferr_pending", 32'(sb.size()), 32'd0);

        push_exp('0, 32'hCAFEBABE, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hBA, 1'b1);
        send_byte(8'hBE, 1'b1);
        cyc(10);
        check("recover_err",  32'(bus.r_err),  32'd0);
        check("recover_done", 32'(bus.r_done), 32'd1);

        // One-cycle low glitch inside a word must not inject a byte.
        push_exp('0, 32'hAABBCCDD, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        rxd = 1'b0;
        cyc(1);
        rxd = 1'b1;
        cyc(12 * CPB);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        cyc(10);
        check("glitch_done", 32'(bus.r_done), 32'd1);
        check("glitch_pending", 32'(sb.size()), 32'd0);

        // Reset in the middle of the second word abandons the load.
        push_exp('0, 32'h01020304, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        check("pre_reset_busy", 32'(bus.r_busy), 32'd1);
        rst_n = 1'b0;
        cyc(1);
        check_all_zero("mid_reset");
        cyc(2);
        rst_n = 1'b1;
        for (int i = 7; i <= 14; i++) begin
            send_byte(8'(i), 1'b1);
        end
        cyc(10);
        check_all_zero("post_reset");

        check("end_pending", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
